// File: rtl/ntt_coeff_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// ntt_pkg
// Shared types and constants for the N=8 NTT front end: coefficient and
// frame types, the modulus, the deserializer state encoding and the 3-bit
// bit-reversal helper used when bit-reversed input ordering is built in
// (macro NTT_DESER_BITREV_EN, consumed by ntt_coeff_deserializer).
// ---------------------------------------------------------------------------
package ntt_pkg;

  localparam int N         = 8;
  localparam int COEFF_W   = 12;
  localparam int Q         = 3329;
  localparam int ERR_CNT_W = 8;

  // Modulus at coefficient width, for direct compare/subtract on coeff_t.
  localparam logic [COEFF_W-1:0] Q_COEFF = 12'd3329;

  typedef logic [COEFF_W-1:0] coeff_t;
  typedef coeff_t [N-1:0]     frame_t;

  // One-bit encoding keeps the state register a single flop.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    SYNC = 1'b1
  } deser_state_t;

  // Reverse the three bits of a beat index: 0..7 -> 0,4,2,6,1,5,3,7.
  function automatic logic [2:0] bitrev3(input logic [2:0] i_idx);
    return {i_idx[0], i_idx[1], i_idx[2]};
  endfunction

endpackage

// File: rtl/ntt_coeff_deserializer_if.sv
// ---------------------------------------------------------------------------
// ntt_coeff_deserializer_if
// Serial coefficient stream into the deserializer.
//   s_valid : beat valid (master -> slave)
//   s_ready : slave can accept a beat (slave -> master)
//   s_coeff : raw 12-bit coefficient, 0..4095 (master -> slave)
//   s_last  : final beat of a frame (master -> slave)
// A beat transfers when s_valid && s_ready at a rising clock edge.
// ---------------------------------------------------------------------------
interface ntt_coeff_deserializer_if;
  import ntt_pkg::*;

  logic   s_valid;
  logic   s_ready;
  coeff_t s_coeff;
  logic   s_last;

  modport master (
    output s_valid,
    output s_coeff,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_coeff,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/ntt_coeff_deserializer_cond_sub_q.sv
// ---------------------------------------------------------------------------
// cond_sub_q
// Combinational conditional subtract of the modulus: o = (i >= Q) ? i - Q : i.
// Brings any 12-bit value (max 4095 < 2Q) into [0, Q). Reused by the
// pointwise stages downstream, so it stays a stand-alone module.
//   i_coeff : 12-bit input value
//   o_coeff : reduced value in [0, Q)
// ---------------------------------------------------------------------------
module cond_sub_q
  import ntt_pkg::*;
(
  input  coeff_t i_coeff,
  output coeff_t o_coeff
);

  // Single conditional subtraction; no further modular arithmetic.
  always_comb begin
    if (i_coeff >= Q_COEFF) begin
      o_coeff = i_coeff - Q_COEFF;
    end else begin
      o_coeff = i_coeff;
    end
  end

endmodule

// File: rtl/ntt_coeff_deserializer.sv
// ---------------------------------------------------------------------------
// ntt_coeff_deserializer
// Front end of the N=8 forward/inverse NTT pipeline. Accepts 12-bit
// coefficients one beat at a time, reduces each into [0, Q), assembles
// 8-beat frames in a two-bank ping-pong buffer with framing checks, and
// presents each complete frame in parallel with a one-cycle valid pulse
// whenever the controller allows (out_en).
//
// Build option: define NTT_DESER_BITREV_EN to store beat i in slot
// bitrev3(i) (bit-reversed input order); otherwise beat i goes to slot i.
//
// Ports
//   clk        : rising-edge clock
//   r          : asynchronous active-low reset
//   s          : slave side of the serial coefficient stream
//   out_en     : downstream permits an emission this cycle
//   valid_out  : one-cycle pulse, coeffs_out holds a new frame
//   coeffs_out : parallel frame, held between pulses
//   frame_err  : one-cycle pulse on a framing error
//   err_cnt    : saturating framing-error count
// ---------------------------------------------------------------------------
module ntt_coeff_deserializer
  import ntt_pkg::*;
(
  input  logic                     clk,
  input  logic                     r,
  ntt_coeff_deserializer_if.slave  s,
  input  logic                     out_en,
  output logic                     valid_out,
  output coeff_t                   coeffs_out [N-1:0],
  output logic                     frame_err,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  // Registered state
  deser_state_t         r_state;
  logic [2:0]           r_idx;
  logic [1:0]           r_occ;
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  frame_t               r_bank [2];
  logic                 r_valid_out;
  coeff_t               r_coeffs_out [N-1:0];
  logic                 r_frame_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Combinational decode
  logic                 w_s_ready;
  logic                 w_accept;
  logic                 w_write;
  logic                 w_complete;
  logic                 w_early;
  logic                 w_missing;
  logic                 w_sync_exit;
  logic                 w_err;
  logic                 w_emit;
  logic [2:0]           w_slot;
  coeff_t               w_reduced;
  deser_state_t         w_state_next;
  logic [2:0]           w_idx_next;
  logic [1:0]           w_occ_next;

  cond_sub_q u_cond_sub_q (
    .i_coeff (s.s_coeff),
    .o_coeff (w_reduced)
  );

`ifdef NTT_DESER_BITREV_EN
  assign w_slot = bitrev3(r_idx);
`else
  assign w_slot = r_idx;
`endif

  // Handshake, framing classification of the current beat, emission request.
  // s_ready depends only on registers and the reset pin, never on out_en.
  // In SYNC the stream is drained regardless of buffer occupancy.
  always_comb begin
    w_s_ready   = r && ((r_state == SYNC) || (r_occ < 2'd2));
    w_accept    = s.s_valid && w_s_ready;
    w_write     = 1'b0;
    w_complete  = 1'b0;
    w_early     = 1'b0;
    w_missing   = 1'b0;
    w_sync_exit = 1'b0;
    if (w_accept && (r_state == FILL)) begin
      if (r_idx == 3'd7) begin
        if (s.s_last) begin
          w_write    = 1'b1;
          w_complete = 1'b1;
        end else begin
          w_missing  = 1'b1;
        end
      end else begin
        if (s.s_last) begin
          w_early = 1'b1;
        end else begin
          w_write = 1'b1;
        end
      end
    end else if (w_accept && (r_state == SYNC)) begin
      w_sync_exit = s.s_last;
    end else begin
      w_sync_exit = 1'b0;
    end
    w_err  = w_early || w_missing;
    w_emit = (r_occ != 2'd0) && out_en;
  end

  // Next state, beat index and occupancy. A completion and an emission on
  // the same edge cancel in occupancy while both bank pointers advance.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FILL: begin
        if (w_missing) begin
          w_state_next = SYNC;
        end else begin
          w_state_next = FILL;
        end
      end
      SYNC: begin
        if (w_sync_exit) begin
          w_state_next = FILL;
        end else begin
          w_state_next = SYNC;
        end
      end
      default: w_state_next = FILL;
    endcase

    if (w_complete || w_err) begin
      w_idx_next = 3'd0;
    end else if (w_write) begin
      w_idx_next = r_idx + 3'd1;
    end else begin
      w_idx_next = r_idx;
    end

    w_occ_next = r_occ + {1'b0, w_complete} - {1'b0, w_emit};
  end

  // Control registers: FSM state, beat index, occupancy and bank pointers.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_state   <= FILL;
      r_idx     <= 3'd0;
      r_occ     <= 2'd0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_occ   <= w_occ_next;
      if (w_complete) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_emit) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Ping-pong banks. Errored beats are not written; a discarded partial bank
  // is simply overwritten by the next frame since idx restarts at 0.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      for (int b = 0; b < 2; b++) begin
        r_bank[b] <= {(N*COEFF_W){1'b0}};
      end
    end else if (w_write) begin
      r_bank[r_wr_bank][w_slot] <= w_reduced;
    end
  end

  // Parallel output frame and its valid pulse.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_valid_out <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_coeffs_out[i] <= {COEFF_W{1'b0}};
      end
    end else begin
      r_valid_out <= w_emit;
      if (w_emit) begin
        for (int i = 0; i < N; i++) begin
          r_coeffs_out[i] <= r_bank[r_rd_bank][i];
        end
      end
    end
  end

  // Framing-error pulse and saturating counter; the pulse keeps firing
  // after the counter has saturated.
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      r_frame_err <= 1'b0;
      r_err_cnt   <= {ERR_CNT_W{1'b0}};
    end else begin
      r_frame_err <= w_err;
      if (w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign s.s_ready  = w_s_ready;
  assign valid_out  = r_valid_out;
  assign coeffs_out = r_coeffs_out;
  assign frame_err  = r_frame_err;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_ntt_coeff_deserializer.sv
// ---------------------------------------------------------------------------
// tb_ntt_coeff_deserializer
// Directed bench for ntt_coeff_deserializer. Good frames push their expected
// parallel vector onto a scoreboard queue when driven; a negedge monitor pops
// and compares on every valid_out pulse and counts frame_err pulses.
// ---------------------------------------------------------------------------
module tb_ntt_coeff_deserializer;
  import ntt_pkg::*;

  logic                 clk;
  logic                 r;
  logic                 out_en;
  logic                 valid_out;
  coeff_t               coeffs_out [N-1:0];
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  ntt_coeff_deserializer_if ifc ();

  ntt_coeff_deserializer dut (
    .clk        (clk),
    .r          (r),
    .s          (ifc),
    .out_en     (out_en),
    .valid_out  (valid_out),
    .coeffs_out (coeffs_out),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
  );

  int     checks;
  int     failures;
  int     vo_pulses;
  int     err_pulses;
  frame_t sb [$];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int slot_of(input int i);
    logic [2:0] b;
    b = i[2:0];
`ifdef NTT_DESER_BITREV_EN
    return int'({b[0], b[1], b[2]});
`else
    return int'(b);
`endif
  endfunction

  function automatic coeff_t reduce(input coeff_t c);
    return (int'(c) >= 3329) ? coeff_t'(int'(c) - 3329) : c;
  endfunction

  function automatic frame_t pack_out();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = coeffs_out[i];
    return f;
  endfunction

  function automatic frame_t make_frame(input int base);
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = coeff_t'(base + i);
    return f;
  endfunction

  // Monitor: scoreboard compare on each valid pulse, count error pulses.
  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (valid_out) begin
      frame_t e;
      vo_pulses++;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL vo_spurious observed=valid_out expected=no_pulse");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("frame_data", pack_out(), e);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input coeff_t c, input logic last);
    int t;
    t = 0;
    ifc.s_valid = 1'b1;
    ifc.s_coeff = c;
    ifc.s_last  = last;
    while ((ifc.s_ready !== 1'b1) && (t < 200)) begin
      @(negedge clk);
      t++;
    end
    checks++;
    assert (ifc.s_ready === 1'b1) else begin
      failures++;
      $error("FAIL beat_timeout observed=s_ready_low expected=accept_within_200");
    end
    @(posedge clk);
    @(negedge clk);
    ifc.s_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t vals);
    frame_t e;
    for (int i = 0; i < N; i++) e[slot_of(i)] = reduce(vals[i]);
    sb.push_back(e);
    for (int i = 0; i < N; i++) send_beat(vals[i], (i == N - 1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0) && (t < 50)) begin
      @(negedge clk);
      t++;
    end
    check("drain_empty", 96'(sb.size()), 96'd0);
  endtask

  initial begin
    int     saved;
    frame_t f;
    clk = 1'b0; r = 1'b1; out_en = 1'b0;
    ifc.s_valid = 1'b0; ifc.s_coeff = 12'd0; ifc.s_last = 1'b0;
    checks = 0; failures = 0; vo_pulses = 0; err_pulses = 0;
    #2 r = 1'b0;
    #20;
    check("rst_valid_out", 96'(valid_out), 96'd0);
    check("rst_frame_err", 96'(frame_err), 96'd0);
    check("rst_err_cnt", 96'(err_cnt), 96'd0);
    check("rst_coeffs", pack_out(), 96'd0);
    check("rst_s_ready", 96'(ifc.s_ready), 96'd0);
    @(negedge clk); r = 1'b1;
    @(negedge clk);

    // Ramp frame with latency check.
    out_en = 1'b1;
    send_frame(make_frame(0));
    check("lat_edge_k", 96'(valid_out), 96'd0);
    @(negedge clk);
    check("lat_edge_k1", 96'(valid_out), 96'd1);
    @(negedge clk);
    check("pulse_width", 96'(valid_out), 96'd0);
    drain();

    // Reduction boundaries.
    f = {12'd3000, 12'd6, 12'd1, 12'd0, 12'd4095, 12'd3330, 12'd3329, 12'd3328};
    send_frame(f);
    drain();

    // Backpressure: two frames fill both banks, third stalls.
    out_en = 1'b0;
    saved = vo_pulses;
    send_frame(make_frame(100));
    send_frame(make_frame(200));
    check("bp_ready_full", 96'(ifc.s_ready), 96'd0);
    ifc.s_valid = 1'b1; ifc.s_coeff = 12'd300; ifc.s_last = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_still_stalled", 96'(ifc.s_ready), 96'd0);
    check("bp_no_pulse", 96'(vo_pulses), 96'(saved));
    ifc.s_valid = 1'b0;
    out_en = 1'b1;
    @(negedge clk);
    check("bp_emit_pulse", 96'(valid_out), 96'd1);
    check("bp_ready_freed", 96'(ifc.s_ready), 96'd1);
    send_frame(make_frame(300));
    drain();
    check("bp_pulse_count", 96'(vo_pulses - saved), 96'd3);

    // Early last on beat 3.
    for (int i = 0; i < 4; i++) send_beat(coeff_t'(10 + i), (i == 3));
    check("early_err_pulse", 96'(frame_err), 96'd1);
    check("early_err_cnt", 96'(err_cnt), 96'd1);
    @(negedge clk);
    check("early_err_clear", 96'(frame_err), 96'd0);
    send_frame(make_frame(400));
    drain();

    // Missing last on beat 7, then SYNC drops beats until s_last.
    for (int i = 0; i < N; i++) send_beat(coeff_t'(20 + i), 1'b0);
    check("miss_err_pulse", 96'(frame_err), 96'd1);
    check("miss_err_cnt", 96'(err_cnt), 96'd2);
    @(negedge clk);
    saved = err_pulses;
    for (int i = 0; i < 4; i++) send_beat(coeff_t'(4000 + i), (i == 3));
    @(negedge clk);
    check("sync_no_err", 96'(err_pulses), 96'(saved));
    check("sync_no_frame", 96'(sb.size()), 96'd0);
    send_frame(make_frame(500));
    drain();

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 5; i++) send_beat(coeff_t'(600 + i), 1'b0);
    r = 1'b0;
    #1;
    check("mid_rst_valid", 96'(valid_out), 96'd0);
    check("mid_rst_err_cnt", 96'(err_cnt), 96'd0);
    check("mid_rst_coeffs", pack_out(), 96'd0);
    check("mid_rst_ready", 96'(ifc.s_ready), 96'd0);
    @(negedge clk); r = 1'b1;
    @(negedge clk);
    saved = err_pulses;
    send_frame(make_frame(700));
    drain();
    check("post_rst_no_err", 96'(err_pulses), 96'(saved));

    // Error counter saturation.
    saved = err_pulses;
    repeat (256) send_beat(12'd5, 1'b1);
    @(negedge clk);
    check("sat_pulses", 96'(err_pulses - saved), 96'd256);
    check("sat_err_cnt", 96'(err_cnt), 96'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
